// File: rtl/conv_arbiter.sv
// Round-robin arbiter that shares one converter between a temperature channel (C1)
// and a device-detect channel (C2), with per-channel result holding and a WAIT timeout.
module conv_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_c1_i,
    input  logic       req_c2_i,
    input  logic       listo_i,
    input  logic [8:0] dato_i,
    output logic       en_conv_o,
    output logic       sel_o,
    output logic       gnt_c1_o,
    output logic       gnt_c2_o,
    output logic [8:0] dato_c1_o,
    output logic [8:0] dato_c2_o,
    output logic       valid_c1_o,
    output logic       valid_c2_o,
    output logic       timeout_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sel_q;
    logic        sel_next;
    logic        last_srv;
    logic [15:0] cnt;
    logic        expire;

    assign expire = (cnt == (TIMEOUT_CYC - 16'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel_q <= 1'b0;
        end else begin
            state <= state_next;
            sel_q <= sel_next;
        end
    end

    // On contention the channel not served last wins; a lone request always wins.
    always_comb begin
        state_next = state;
        sel_next   = sel_q;
        case (state)
            IDLE: begin
                if (req_c1_i || req_c2_i) begin
                    state_next = WAIT;
                    if (req_c1_i && req_c2_i) begin
                        sel_next = ~last_srv;
                    end else begin
                        sel_next = req_c2_i;
                    end
                end
            end
            WAIT: begin
                if (listo_i || expire) begin
                    state_next = REL;
                end
            end
            REL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        en_conv_o = (state == WAIT);
        gnt_c1_o  = (state == WAIT) && !sel_q;
        gnt_c2_o  = (state == WAIT) && sel_q;
        busy_o    = (state != IDLE);
        sel_o     = sel_q;
    end

    // A completion on the expiry edge takes priority, so timeout only fires without listo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 16'd0;
            last_srv   <= 1'b1;
            dato_c1_o  <= 9'd0;
            dato_c2_o  <= 9'd0;
            valid_c1_o <= 1'b0;
            valid_c2_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            valid_c1_o <= 1'b0;
            valid_c2_o <= 1'b0;
            timeout_o  <= 1'b0;
            if (state == WAIT) begin
                cnt <= cnt + 16'd1;
                if (listo_i) begin
                    if (sel_q) begin
                        dato_c2_o  <= dato_i;
                        valid_c2_o <= 1'b1;
                    end else begin
                        dato_c1_o  <= dato_i;
                        valid_c1_o <= 1'b1;
                    end
                end else if (expire) begin
                    timeout_o <= 1'b1;
                end
            end else begin
                cnt <= 16'd0;
            end
            if (state == REL) begin
                last_srv <= sel_q;
            end
        end
    end

endmodule

// File: tb/tb_conv_arbiter.sv
// Self-checking bench for conv_arbiter: result/timeout pulses are scoreboarded,
// grant order, latency, reset and spurious-done behaviour are checked inline.
module tb_conv_arbiter;

    localparam logic [15:0] TCYC = 16'd8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_c1_i = 1'b0;
    logic       req_c2_i = 1'b0;
    logic       listo_i = 1'b0;
    logic [8:0] dato_i = 9'd0;
    logic       en_conv_o, sel_o, gnt_c1_o, gnt_c2_o;
    logic [8:0] dato_c1_o, dato_c2_o;
    logic       valid_c1_o, valid_c2_o, timeout_o, busy_o;

    typedef struct {
        int kind;
        int chan;
        int data;
    } sbEntry_t;

    sbEntry_t   sbQueue[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [8:0] expDato1 = 9'd0;
    logic [8:0] expDato2 = 9'd0;
    int         grantCh;
    int         grantCyc;
    int         order[4] = '{0, 1, 0, 1};

    conv_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .req_c1_i(req_c1_i), .req_c2_i(req_c2_i),
        .listo_i(listo_i), .dato_i(dato_i),
        .en_conv_o(en_conv_o), .sel_o(sel_o),
        .gnt_c1_o(gnt_c1_o), .gnt_c2_o(gnt_c2_o),
        .dato_c1_o(dato_c1_o), .dato_c2_o(dato_c2_o),
        .valid_c1_o(valid_c1_o), .valid_c2_o(valid_c2_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitGrant(output int ch, output int cycles);
        ch = -1;
        cycles = 0;
        while (ch < 0 && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (gnt_c1_o || gnt_c2_o) ch = gnt_c2_o ? 1 : 0;
        end
        if (ch < 0) checkOutput("grant_wait_expired", 0, 1);
    endtask

    task automatic applyStimulus(input logic [8:0] d, input int chan);
        sbEntry_t e;
        e.kind = 1 + chan;
        e.chan = chan;
        e.data = int'(d);
        sbQueue.push_back(e);
        if (chan == 0) expDato1 = d;
        else expDato2 = d;
        listo_i = 1'b1;
        dato_i = d;
        @(negedge clk);
        listo_i = 1'b0;
        dato_i = 9'd0;
    endtask

    task automatic checkRelease(input string tag);
        checkOutput({tag, "_rel_grants"}, int'({gnt_c2_o, gnt_c1_o}), 0);
        checkOutput({tag, "_rel_en"}, int'(en_conv_o), 0);
        checkOutput({tag, "_rel_busy"}, int'(busy_o), 1);
        @(negedge clk);
        checkOutput({tag, "_idle_busy"}, int'(busy_o), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_en"}, int'(en_conv_o), 0);
        checkOutput({tag, "_sel"}, int'(sel_o), 0);
        checkOutput({tag, "_gnt"}, int'({gnt_c2_o, gnt_c1_o}), 0);
        checkOutput({tag, "_dato1"}, int'(dato_c1_o), 0);
        checkOutput({tag, "_dato2"}, int'(dato_c2_o), 0);
        checkOutput({tag, "_pulses"}, int'({valid_c1_o, valid_c2_o, timeout_o}), 0);
        checkOutput({tag, "_busy"}, int'(busy_o), 0);
    endtask

    // Every pulse must match the oldest scoreboard entry; extra or longer pulses find it empty.
    always @(negedge clk) begin
        sbEntry_t e;
        int obsKind;
        int obsData;
        if (rst && (valid_c1_o || valid_c2_o || timeout_o)) begin
            checkOutput("pulse_onehot", int'(valid_c1_o) + int'(valid_c2_o) + int'(timeout_o), 1);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                e = sbQueue.pop_front();
                obsKind = valid_c1_o ? 1 : (valid_c2_o ? 2 : 3);
                obsData = (e.chan == 1) ? int'(dato_c2_o) : int'(dato_c1_o);
                checkOutput("pulse_kind", obsKind, e.kind);
                checkOutput("pulse_data", obsData, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sbEntry_t t;
        logic [8:0] d;

        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b1;
        @(negedge clk);

        // single request on C1, dropped during WAIT
        req_c1_i = 1'b1;
        waitGrant(grantCh, grantCyc);
        checkOutput("single_grant_ch", grantCh, 0);
        checkOutput("single_grant_lat", grantCyc, 1);
        checkOutput("single_sel", int'(sel_o), 0);
        @(negedge clk);
        req_c1_i = 1'b0;
        checkOutput("deassert_no_abort", int'(en_conv_o), 1);
        repeat (2) @(negedge clk);
        checkOutput("single_sel_late", int'(sel_o), 0);
        applyStimulus(9'h1A5, 0);
        checkOutput("single_dato1", int'(dato_c1_o), 'h1A5);
        checkOutput("single_sel_done", int'(sel_o), 0);
        checkRelease("single");

        // timeout on C2 while C1 starts requesting
        req_c2_i = 1'b1;
        waitGrant(grantCh, grantCyc);
        checkOutput("to_grant_ch", grantCh, 1);
        checkOutput("to_sel", int'(sel_o), 1);
        t.kind = 3;
        t.chan = 1;
        t.data = int'(expDato2);
        sbQueue.push_back(t);
        req_c1_i = 1'b1;
        repeat (7) @(negedge clk);
        checkOutput("timeout_early", int'(timeout_o), 0);
        @(negedge clk);
        checkOutput("timeout_at_8", int'(timeout_o), 1);
        checkOutput("timeout_dato2_held", int'(dato_c2_o), 0);
        checkOutput("timeout_en_low", int'(en_conv_o), 0);
        waitGrant(grantCh, grantCyc);
        checkOutput("after_to_lat", grantCyc, 2);

        // contention with both requests held
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                waitGrant(grantCh, grantCyc);
                checkOutput("rr_grant_lat", grantCyc, 1);
            end
            checkOutput("rr_grant_ch", grantCh, order[i]);
            checkOutput("rr_sel", int'(sel_o), order[i]);
            checkOutput("rr_gnt_onehot", int'({gnt_c2_o, gnt_c1_o}), order[i] == 1 ? 2 : 1);
            repeat (2) @(negedge clk);
            d = 9'($urandom_range(0, 511));
            applyStimulus(d, order[i]);
            checkOutput("rr_dato", order[i] == 1 ? int'(dato_c2_o) : int'(dato_c1_o), int'(d));
            checkRelease("rr");
        end

        // completion on the expiry edge
        waitGrant(grantCh, grantCyc);
        checkOutput("tie_grant_ch", grantCh, 0);
        repeat (7) @(negedge clk);
        req_c1_i = 1'b0;
        req_c2_i = 1'b0;
        applyStimulus(9'h155, 0);
        checkOutput("tie_no_timeout", int'(timeout_o), 0);
        checkOutput("tie_valid", int'(valid_c1_o), 1);
        checkRelease("tie");

        // asynchronous reset two cycles into WAIT
        req_c2_i = 1'b1;
        waitGrant(grantCh, grantCyc);
        checkOutput("rst_pre_grant_ch", grantCh, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        req_c1_i = 1'b1;
        expDato1 = 9'd0;
        expDato2 = 9'd0;
        #1;
        checkOutput("reset_async_en", int'(en_conv_o), 0);
        checkResetState("midreset");
        @(negedge clk);
        rst = 1'b1;
        waitGrant(grantCh, grantCyc);
        checkOutput("reset_first_c1", grantCh, 0);
        checkOutput("reset_first_lat", grantCyc, 1);
        req_c1_i = 1'b0;
        req_c2_i = 1'b0;
        applyStimulus(9'h0AA, 0);
        checkRelease("post_reset");

        // spurious done while idle
        listo_i = 1'b1;
        dato_i = 9'h1FF;
        repeat (3) @(negedge clk);
        listo_i = 1'b0;
        dato_i = 9'd0;
        checkOutput("spurious_dato1", int'(dato_c1_o), int'(expDato1));
        checkOutput("spurious_dato2", int'(dato_c2_o), int'(expDato2));
        checkOutput("spurious_busy", int'(busy_o), 0);

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sbQueue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd1000: the maximum number of cycles in WAIT before a conversion is abandoned (legal range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; the block is held in reset while rst=0.
REQ-004 req_c1_i  input  1  level request for a conversion from channel 1 (temperature).
REQ-005 req_c2_i  input  1  level request for a conversion from channel 2 (device detect).
REQ-006 listo_i  input  1  shared converter done strobe; dato_i is valid in the same cycle.
REQ-007 dato_i  input  9  shared converter result.
REQ-008 en_conv_o  output  1  enable to the shared converter.
REQ-009 sel_o  output  1  converter channel select: 0=C1, 1=C2.
REQ-010 gnt_c1_o, gnt_c2_o  output  1 each  grant to the currently served requester; one-hot or zero.
REQ-011 dato_c1_o, dato_c2_o  output  9 each  last good result per channel, held.
REQ-012 valid_c1_o, valid_c2_o  output  1 each  one-cycle pulse when the matching dato_cX_o updates.
REQ-013 timeout_o  output  1  one-cycle pulse when a conversion is abandoned.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, WAIT and REL. All outputs SHALL be registered or decoded from state and registers only, so no output depends combinationally on an input.
REQ-016 IDLE: on an edge where req_c1_i or req_c2_i is 1, the block SHALL select a channel and enter WAIT.
- If only one request is high, that channel is selected.
- If both are high, the channel other than last_srv is selected (round-robin).
REQ-017 last_srv SHALL reset to C2, so C1 wins the first contention.
REQ-018 WAIT: en_conv_o=1, sel_o=selected channel, and the matching gnt_cX_o=1 for every cycle in the state.
REQ-019 WAIT: a 16-bit cycle counter SHALL clear on entry and increment on each edge that stays in WAIT.
REQ-020 WAIT with listo_i=1 at an edge: dato_i SHALL be captured into the selected dato_cX_o, and the matching valid_cX_o SHALL be 1 for exactly the next cycle; next state is REL.
REQ-021 WAIT with listo_i=0 and counter=TIMEOUT_CYC-1 at an edge: timeout_o SHALL be 1 for the next cycle, dato_cX_o SHALL be unchanged, and the next state is REL.
REQ-022 If listo_i=1 on the timeout edge, the completion (REQ-020) SHALL win and timeout_o SHALL stay 0.
REQ-023 REL: en_conv_o=0, both grants 0; last_srv SHALL be updated to the served channel, and the next state is IDLE unconditionally (one-cycle guard).
REQ-024 Latency:
- request sampled at edge k gives grant/en high from edge k+1;
- listo at edge m gives valid/data at m+1 and IDLE at m+2;
- the earliest next grant is at m+3.
REQ-025 Deassertion of the served request during WAIT SHALL NOT abort the conversion.
REQ-026 listo_i in IDLE or REL SHALL be ignored: no data update and no pulse.
REQ-027 A requester holding req high SHALL be re-served after each REL; with both requests held continuously, grants SHALL alternate C1, C2, C1, ...
REQ-028 At most one of valid_c1_o, valid_c2_o and timeout_o SHALL be high in any cycle.

Reset
REQ-029 rst=0 SHALL immediately force:
- state=IDLE, counter=0, last_srv=C2;
- en_conv_o=0, sel_o=0, both grants 0;
- dato_c1_o=dato_c2_o=9'd0;
- all pulses 0, busy_o=0.
REQ-030 Reset asserted mid-WAIT SHALL drop en_conv_o asynchronously; the pending result is discarded.
REQ-031 After rst returns to 1, the first edge SHALL evaluate requests from IDLE.

Verification
REQ-032 Single request: req_c1_i=1, listo_i=1 with dato_i=9'h1A5 three cycles after grant -> dato_c1_o=9'h1A5, valid_c1_o pulses one cycle, sel_o=0 throughout.
REQ-033 Contention: both requests held, listo after 2 cycles each time -> grant order C1, C2, C1, C2; each grant separated by a 1-cycle REL plus 1-cycle IDLE.
REQ-034 Timeout: TIMEOUT_CYC=8, req_c2_i=1, listo_i never -> timeout_o pulses 8 cycles after WAIT entry, dato_c2_o stays 0, and req_c1_i then wins the next arbitration.
REQ-035 Tie: TIMEOUT_CYC=8, listo_i=1 exactly on the 8th WAIT edge -> valid pulse, timeout_o=0.
REQ-036 Reset mid-WAIT: rst=0 two cycles into WAIT -> en_conv_o=0 without waiting for a clk edge, all outputs at reset values, and a C1 grant first after release.
REQ-037 Spurious done: listo_i=1 while IDLE with no requests -> no valid pulse and both data outputs unchanged.
